// File: rtl/cache_serial_tx_16.sv
`default_nettype none
// ============================================================================
// cache_serial_tx_16 : accepts one word over valid/ready, sends it bit-serially
// with start/stop framing. Optional parity: CACHE_SERIAL_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
module cache_serial_tx_16 #(
   parameter int WIDTH = 16,
   parameter int DIV   = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_req,
   output logic             load_rdy,
   output logic             tx_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(WIDTH);
   localparam logic [CW-1:0] C_SLOT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] C_IDX_LAST  = IW'(WIDTH - 1);

`ifdef CACHE_SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3
   } state_t;
`endif

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [IW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic             tx_n;
   logic             done_n;
   logic             slot_end;
`ifdef CACHE_SERIAL_TX_PARITY_EN
   logic             par, par_n;
`endif

   assign slot_end = (cnt == C_SLOT_LAST);
   assign load_rdy = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         shreg  <= '0;
         tx_out <= 1'b1;
         done   <= 1'b0;
`ifdef CACHE_SERIAL_TX_PARITY_EN
         par    <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         shreg  <= shreg_n;
         tx_out <= tx_n;
         done   <= done_n;
`ifdef CACHE_SERIAL_TX_PARITY_EN
         par    <= par_n;
`endif
      end
   end

   // tx_out is registered, so each branch computes the level for the next slot.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      tx_n    = tx_out;
      done_n  = 1'b0;
`ifdef CACHE_SERIAL_TX_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (load_req) begin
               state_n = START;
               shreg_n = data_in;
               cnt_n   = '0;
               idx_n   = '0;
               tx_n    = 1'b0;
`ifdef CACHE_SERIAL_TX_PARITY_EN
               par_n   = ^data_in;
`endif
            end
         end
         START: begin
            if (slot_end) begin
               state_n = DATA;
               cnt_n   = '0;
               tx_n    = shreg[0];
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (slot_end) begin
               cnt_n   = '0;
               shreg_n = shreg >> 1;
               if (idx == C_IDX_LAST) begin
                  idx_n = '0;
`ifdef CACHE_SERIAL_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = par;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  idx_n = idx + 1'b1;
                  tx_n  = shreg[1];
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef CACHE_SERIAL_TX_PARITY_EN
         PARITY: begin
            if (slot_end) begin
               state_n = STOP;
               cnt_n   = '0;
               tx_n    = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            if (slot_end) begin
               state_n = IDLE;
               cnt_n   = '0;
               tx_n    = 1'b1;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/cache_serial_tx_16.md
Name: cache_serial_tx_16

Overview:
- Read-side companion to the 16-bit cache register. It accepts one stored word over a parallel valid/ready handshake and transmits it on a single wire, bit-serially, with start/stop framing.
- Sits between the cache register output and an off-block serial link.
- Provides the unload direction for data that the cache register loads in parallel.

Parameters:
- WIDTH, 16, data word width in bits; legal range 2..32.
- DIV, 4, clock cycles per serial bit; legal range 1..255.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous active-high reset, sampled on the rising edge of CLK.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted transfer.
- load_req  input  1  requester has a valid word on data_in.
- load_rdy  output  1  block can accept a word; high only in IDLE.
- tx_out  output  1  registered serial line; idles high.
- busy  output  1  high while a frame is in flight (any state except IDLE).
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset values, taking effect on the first CLK edge with RST=1:
  - state=IDLE, tx_out=1, load_rdy=1, busy=0, done=0.
  - Shift register and counters cleared.
- RST has priority over every other event. RST asserted mid-frame aborts the frame: tx_out=1 from the next edge, and no done pulse is issued.
- Handshake:
  - A transfer occurs on an edge where load_req=1 and load_rdy=1; data_in is captured into the shift register.
  - load_req while load_rdy=0 is ignored. The requester holds load_req and data_in stable until accepted.
  - Once captured, data_in may change freely without affecting the frame.
- Frame format, per bit slot of exactly DIV cycles:
  - one start bit = 0;
  - WIDTH data bits, LSB first;
  - [parity bit, see Optional Feature];
  - one stop bit = 1.
- State machine, held in each state for the stated number of bit slots:
  - IDLE: tx_out=1. On transfer -> START.
  - START: 1 slot, tx_out=0, then -> DATA.
  - DATA: WIDTH slots. tx_out = shift-register LSB; shift right at the end of each slot. After WIDTH slots -> PARITY if enabled, else STOP.
  - PARITY: 1 slot, only when enabled, then -> STOP.
  - STOP: 1 slot, tx_out=1, then -> IDLE.
- Counters:
  - Bit-cycle counter runs 0..DIV-1 and wraps to 0 on each slot boundary.
  - Bit index runs 0..WIDTH-1.
  - Both reset to 0 on entry to START.
- Timing, for a transfer accepted at edge k (NB = number of bit slots in the frame):
  - tx_out=0 is visible after edge k.
  - Data bit i is visible after edge k+DIV*(1+i).
  - The stop bit ends at edge k+DIV*NB. At that edge state=IDLE, done=1 for exactly one cycle, and load_rdy=1.
  - Without parity, NB=WIDTH+2.
- Back-to-back: the earliest next acceptance is edge k+DIV*NB+1, so at least one idle-high cycle separates frames.
- DIV=1 is legal: one cycle per bit, with no extra bubbles inside the frame.
- done and load_rdy are high together in the cycle after the frame. A transfer accepted on that edge behaves normally.

Optional Feature:
- Macro: CACHE_SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA; tx_out = XOR of all captured data bits (even parity).
  - NB=WIDTH+3.
- Undefined:
  - PARITY state and parity logic are absent; NB=WIDTH+2.
  - Port list is identical in both builds.

Test Plan:
- Reset, defaults (WIDTH=16, DIV=4): RST high 2 cycles -> tx_out=1, load_rdy=1, busy=0, done=0. With load_req=0, outputs remain at those values for 20 cycles.
- Single frame: data_in=16'hA5C3, load_req pulsed one cycle at edge k -> tx_out sequence (4 cycles/bit) is:
  - 0;
  - 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
  - 1.
  - done=1 at edge k+72 only; busy is high for cycles k..k+71.
- Ignored request: while busy, load_req=1 with data_in=16'hFFFF -> frame bits unchanged, and no second capture until load_rdy=1.
- Back-to-back: load_req held high with 16'h0001 then 16'h8000 -> the second start bit begins at edge k+73. Exactly one idle-high cycle separates the frames; two done pulses occur.
- Reset mid-frame: RST=1 during data bit 5 -> tx_out=1 and busy=0 the next edge, no done pulse, and a new frame with 16'h00FF then transmits correctly.
- Parity build (CACHE_SERIAL_TX_PARITY_EN, DIV=1):
  - data_in=16'h0007 -> parity bit=1 at bit slot 17, stop at slot 18, done at edge k+19.
  - data_in=16'h0003 -> parity bit=0.
